// File: rtl/alu_seq_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: widths, op codes,
// FSM state encoding and the single-cycle logic-op evaluator.
package alu_seq_pkg;

    localparam int OPW  = 4;
    localparam int RESW = 8;

    localparam logic [2:0] OP_INC   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_ADD2  = 3'b010;
    localparam logic [2:0] OP_XOROR = 3'b011;
    localparam logic [2:0] OP_REDOR = 3'b100;
    localparam logic [2:0] OP_CAT   = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        EVAL = 2'd2,
        DONE = 2'd3
    } state_t;

    // Ops that run through the shared full-adder slice.
    function automatic logic is_serial(input logic [2:0] op);
        return (op == OP_INC) || (op == OP_ADD) || (op == OP_ADD2);
    endfunction

    // Result of the non-arithmetic ops; unused codes yield zero.
    function automatic logic [RESW-1:0] logic_op(input logic [2:0] op,
                                                 input logic [OPW-1:0] a,
                                                 input logic [OPW-1:0] b);
        logic [RESW-1:0] r;
        case (op)
            OP_XOROR: r = {a | b, a ^ b};
            OP_REDOR: r = {7'b0, |{a, b}};
            OP_CAT:   r = {a, b};
            default:  r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/alu_op_sequencer_if.sv
// Request/result handshake bundle between a requester and the sequencer.
interface alu_op_sequencer_if;
    import alu_seq_pkg::*;

    logic                req_valid;
    logic                req_ready;
    logic [2:0]          op;
    logic [OPW-1:0]      a;
    logic [OPW-1:0]      b;
    logic                use_acc;
    logic                res_valid;
    logic                res_ready;
    logic [RESW-1:0]     result;

    // Requester side: issues operations and consumes results.
    modport master (
        output req_valid, op, a, b, use_acc, res_ready,
        input  req_ready, res_valid, result
    );

    // Sequencer side.
    modport slave (
        input  req_valid, op, a, b, use_acc, res_ready,
        output req_ready, res_valid, result
    );
endinterface

// File: rtl/alu_op_sequencer_fa_bit.sv
// Combinational 1-bit full adder; the single arithmetic resource that the
// sequencer time-multiplexes across operand bits.
module fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);
    assign s_o    = a_i ^ b_i ^ cin_i;
    assign cout_o = (a_i & b_i) | (a_i & cin_i) | (b_i & cin_i);
endmodule

// File: rtl/alu_op_sequencer.sv
// Multi-cycle ALU controller: accepts one op at a time, runs additions
// bit-serially through one shared full-adder slice, evaluates logic ops in a
// single cycle, and owns an 8-bit accumulator holding the last result.
module alu_op_sequencer
    import alu_seq_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    alu_op_sequencer_if.slave   bus,
    output logic [RESW-1:0]     acc_o,
    output logic                busy_o
);

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [2:0]      op_q, op_d;
    logic [OPW-1:0]  a_q, a_d;
    logic [OPW-1:0]  b_q, b_d;
    logic [RESW-1:0] result_q, result_d;
    logic [RESW-1:0] acc_q, acc_d;

    logic            fa_s;
    logic            fa_cout;

    // The shared slice always looks at the bit currently being processed.
    fa_bit u_fa (
        .a_i    (a_q[idx_q]),
        .b_i    (b_q[idx_q]),
        .cin_i  (carry_q),
        .s_o    (fa_s),
        .cout_o (fa_cout)
    );

    // State and datapath registers; reset discards any in-flight op.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            acc_q    <= acc_d;
        end
    end

    // Next-state logic: accept, serial add steps, logic eval, result hold.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        acc_d    = acc_q;

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    op_d    = bus.op;
                    a_d     = bus.a;
                    // Increment is an add with B pinned to one; otherwise B
                    // may come from the accumulator's low nibble.
                    if (bus.op == OP_INC)
                        b_d = 4'b0001;
                    else if (bus.use_acc)
                        b_d = acc_q[OPW-1:0];
                    else
                        b_d = bus.b;
                    idx_d   = '0;
                    carry_d = 1'b0;
                    state_d = is_serial(bus.op) ? ADD : EVAL;
                end
            end
            ADD: begin
                result_d[idx_q] = fa_s;
                carry_d         = fa_cout;
                idx_d           = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    // Final carry becomes bit 4; the sum is zero-extended.
                    result_d[RESW-1:OPW] = {3'b000, fa_cout};
                    acc_d                = result_d;
                    state_d              = DONE;
                end
            end
            EVAL: begin
                result_d = logic_op(op_q, a_q, b_q);
                acc_d    = result_d;
                state_d  = DONE;
            end
            DONE: begin
                if (bus.res_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign acc_o         = acc_q;
    assign busy_o        = (state_q == ADD) || (state_q == EVAL);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed-vector bench for alu_op_sequencer with hand-computed results.
module tb_alu_op_sequencer;
    import alu_seq_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] acc;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_op_sequencer_if alu_if ();

    alu_op_sequencer dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (alu_if),
        .acc_o  (acc),
        .busy_o (busy)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op with res_ready high; check latency, result, acc and the
    // return of req_ready at the result-handshake edge.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [3:0] a,
                          input logic [3:0] b, input logic ua, input logic [7:0] exp,
                          input int lat);
        int cycles;
        @(negedge clk);
        check({tag, "_req_ready"}, 8'(alu_if.req_ready), 8'h01);
        alu_if.op        = op;
        alu_if.a         = a;
        alu_if.b         = b;
        alu_if.use_acc   = ua;
        alu_if.res_ready = 1'b1;
        alu_if.req_valid = 1'b1;
        @(posedge clk);
        #1;
        alu_if.req_valid = 1'b0;
        check({tag, "_busy"}, 8'(busy), 8'h01);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!alu_if.res_valid && cycles < 20);
        check({tag, "_latency"}, 8'(cycles), 8'(lat));
        check({tag, "_result"}, alu_if.result, exp);
        check({tag, "_acc"}, acc, exp);
        $display("op=%b a=%h b=%h use_acc=%b result=%h acc=%h latency=%0d",
                 op, a, b, ua, alu_if.result, acc, cycles);
        @(posedge clk);
        #1;
        check({tag, "_hs_res_valid"}, 8'(alu_if.res_valid), 8'h00);
        check({tag, "_hs_req_ready"}, 8'(alu_if.req_ready), 8'h01);
    endtask

    initial begin
        int   cycles;
        logic saw_valid;

        rst              = 1'b1;
        alu_if.req_valid = 1'b0;
        alu_if.op        = '0;
        alu_if.a         = '0;
        alu_if.b         = '0;
        alu_if.use_acc   = 1'b0;
        alu_if.res_ready = 1'b1;

        repeat (2) @(negedge clk);
        check("rst_req_ready", 8'(alu_if.req_ready), 8'h01);
        check("rst_res_valid", 8'(alu_if.res_valid), 8'h00);
        check("rst_result", alu_if.result, 8'h00);
        check("rst_acc", acc, 8'h00);
        check("rst_busy", 8'(busy), 8'h00);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_req_ready", 8'(alu_if.req_ready), 8'h01);
        check("idle_res_valid", 8'(alu_if.res_valid), 8'h00);
        $display("reset and idle state checked");

        run_op("add_ff",   OP_ADD,   4'hF, 4'hF, 1'b0, 8'h1E, 4);
        run_op("inc_f",    OP_INC,   4'hF, 4'h9, 1'b0, 8'h10, 4);
        run_op("add_acc",  OP_ADD,   4'h1, 4'h7, 1'b1, 8'h01, 4);
        run_op("xoror",    OP_XOROR, 4'b1100, 4'b1010, 1'b0, 8'hE6, 1);
        run_op("redor_0",  OP_REDOR, 4'h0, 4'h0, 1'b0, 8'h00, 1);
        run_op("redor_1",  OP_REDOR, 4'h0, 4'h1, 1'b0, 8'h01, 1);
        run_op("cat",      OP_CAT,   4'h3, 4'hC, 1'b0, 8'h3C, 1);
        run_op("cat_acc",  OP_CAT,   4'h5, 4'h1, 1'b1, 8'h5C, 1);
        run_op("op111",    3'b111,   4'hA, 4'h5, 1'b0, 8'h00, 1);
        run_op("add2",     OP_ADD2,  4'h9, 4'h8, 1'b0, 8'h11, 4);

        // Backpressure: hold the result while a new request waits.
        @(negedge clk);
        alu_if.op        = OP_XOROR;
        alu_if.a         = 4'hF;
        alu_if.b         = 4'h0;
        alu_if.use_acc   = 1'b0;
        alu_if.res_ready = 1'b0;
        alu_if.req_valid = 1'b1;
        @(posedge clk);
        #1;
        alu_if.req_valid = 1'b0;
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!alu_if.res_valid && cycles < 20);
        check("bp_latency", 8'(cycles), 8'h01);
        @(negedge clk);
        alu_if.op        = OP_CAT;
        alu_if.a         = 4'h1;
        alu_if.b         = 4'h2;
        alu_if.req_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_result", alu_if.result, 8'hFF);
            check("bp_req_ready", 8'(alu_if.req_ready), 8'h00);
            check("bp_res_valid", 8'(alu_if.res_valid), 8'h01);
        end
        $display("backpressure held result=%h for 10 cycles", alu_if.result);
        @(negedge clk);
        alu_if.res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_hs_res_valid", 8'(alu_if.res_valid), 8'h00);
        check("bp_hs_req_ready", 8'(alu_if.req_ready), 8'h01);
        @(posedge clk);
        #1;
        alu_if.req_valid = 1'b0;
        check("bp_next_busy", 8'(busy), 8'h01);
        check("bp_next_req_ready", 8'(alu_if.req_ready), 8'h00);
        @(posedge clk);
        #1;
        check("bp_next_res_valid", 8'(alu_if.res_valid), 8'h01);
        check("bp_next_result", alu_if.result, 8'h12);
        check("bp_next_acc", acc, 8'h12);
        $display("op=%b a=1 b=2 after backpressure result=%h acc=%h", OP_CAT, alu_if.result, acc);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of a serial add.
        @(negedge clk);
        alu_if.op        = OP_ADD;
        alu_if.a         = 4'hF;
        alu_if.b         = 4'hF;
        alu_if.use_acc   = 1'b0;
        alu_if.req_valid = 1'b1;
        @(posedge clk);
        #1;
        alu_if.req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_req_ready", 8'(alu_if.req_ready), 8'h01);
        check("midrst_busy", 8'(busy), 8'h00);
        check("midrst_res_valid", 8'(alu_if.res_valid), 8'h00);
        check("midrst_result", alu_if.result, 8'h00);
        check("midrst_acc", acc, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        saw_valid = 1'b0;
        repeat (8) begin
            @(posedge clk);
            #1;
            if (alu_if.res_valid) saw_valid = 1'b1;
        end
        check("midrst_no_res_valid", 8'(saw_valid), 8'h00);
        $display("mid-add reset discarded op, res_valid seen=%b", saw_valid);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Multi-cycle controller that sequences the 4-bit ALU function set over a single shared full-adder bit slice and owns an 8-bit accumulator. It sits between the switch/key front end, or any upstream requester, and the LEDR/HEX display path. It accepts one operation at a time over a valid/ready handshake and returns an 8-bit result over a second valid/ready handshake. Arithmetic ops run bit-serially (4 adder cycles); logic ops complete in one cycle.

## Interface
Parameters:
- none; all widths are fixed by the ALU: 4-bit operands, 8-bit result.

Ports:
- Clock  in  1  single clock; all state changes on its rising edge.
- Reset  in  1  asynchronous, active-high; clears all state immediately.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- op  in  3  function code, see Operation.
- a  in  4  operand A.
- b  in  4  operand B.
- use_acc  in  1  at accept, replace B with acc[3:0].
- res_valid  out  1  result available; high only in DONE.
- res_ready  in  1  consumer takes the result.
- result  out  8  registered result; stable while res_valid is high.
- acc  out  8  accumulator; holds the last completed result.
- busy  out  1  high in ADD or EVAL.

Reset values: req_ready=1 (IDLE), res_valid=0, result=8'h00, acc=8'h00, busy=0.

## Operation
- Accept when req_valid && req_ready.
  - Capture op, a, and B into internal registers. B is `use_acc ? acc[3:0] : b`.
  - Clear the bit index and the carry.
- Op codes:
  - 000: A+1 (serial, B forced to 4'b0001).
  - 001: A+B (serial).
  - 010: A+B (serial; identical datapath to 001).
  - 011: {A|B, A^B}, with the OR in bits 7:4 and the XOR in bits 3:0.
  - 100: {7'b0, |{A,B}}.
  - 101: {A,B}.
  - 110 and 111: 8'h00.
- Serial add:
  - Each ADD cycle feeds A[i], B[i] and the carry register into the shared bit slice.
  - The slice's sum is written to result[i]; its cout is written to the carry register.
  - After i=3, result[4] takes the final cout and result[7:5] are 0.
  - The result is the unsigned 5-bit sum, zero-extended. Max is 15+15 = 5'b11110. There is no overflow flag.
- FSM:
  - IDLE: on accept, go to ADD for op ∈ {000, 001, 010}, otherwise go to EVAL.
  - ADD: index increments by 1 each cycle; when index==3, go to DONE.
  - EVAL: compute the logic result, go to DONE.
  - DONE: hold result; when res_ready, go to IDLE.
- On every transition into DONE, acc is loaded with the new result in the same edge.
- Inputs are ignored outside the accept handshake. res_ready is ignored outside DONE.
- Reset mid-operation: the in-flight op is discarded. State returns to IDLE and all registers to their reset values asynchronously. No partial result is ever presented.

## Timing
- Accept at edge E0.
- Logic ops: EVAL during the cycle after E0; DONE and res_valid=1 from E1.
- Add ops:
  - Bits are written at E1, E2, E3 and E4.
  - DONE and res_valid=1 from E4.
- Result-handshake edge Ed (res_valid && res_ready sampled high):
  - res_valid falls at Ed.
  - req_ready rises at Ed.
  - The earliest next accept is Ed+1.
- Throughput:
  - One logic op per 3 cycles with res_ready held high.
  - One add op per 6 cycles.
- acc changes only at the DONE-entry edge. A use_acc request therefore sees the previous result, never a partial sum.
- result bits under construction may toggle during ADD. Consumers must qualify result with res_valid.

## Structure
- Shared package alu_seq_pkg:
  - op-code constants OP_INC, OP_ADD, OP_ADD2, OP_XOROR, OP_REDOR, OP_CAT.
  - state encoding IDLE/ADD/EVAL/DONE.
  - width constants OPW=4, RESW=8.
- One sub-module, fa_bit: a combinational 1-bit full adder.
  - Inputs: a, b, cin.
  - Outputs: s = a^b^cin, cout = majority.
  - Instantiated exactly once; it is the shared resource being sequenced.
- Everything else, including the FSM, index counter, carry register, result/acc registers and the logic-op mux, lives in alu_op_sequencer.

## Test plan
- Reset then idle, no stimulus:
  - req_ready=1, res_valid=0, result=acc=8'h00.
  - Reset asserted mid-ADD (after E2) forces IDLE within the same cycle; no res_valid pulse follows.
- op=001, a=4'hF, b=4'hF, res_ready=1:
  - res_valid rises at E4 with result=8'h1E; acc=8'h1E.
  - req_ready is back at the handshake edge.
- op=000, a=4'hF:
  - result=8'h10 at E4.
- Then op=001, a=4'h1, use_acc=1 (acc[3:0]=0):
  - result=8'h01.
- op=011, a=4'b1100, b=4'b1010:
  - res_valid at E1, result=8'hE6.
- op=100, a=0, b=0:
  - result=8'h00.
- op=101, a=4'h3, b=4'hC:
  - result=8'h3C.
- op=111:
  - result=8'h00.
- Backpressure:
  - Hold res_ready=0 for 10 cycles in DONE with req_valid=1. result stays stable, req_ready stays 0, and no second accept occurs.
  - Raising res_ready completes the handshake; the new request is accepted on the next edge.
